// File: rtl/param_ddr_writer.sv
// Slices one precomputed parameter into BEAT_WIDTH-wide write beats.
// Each beat goes to the DDR slot owned by that parameter's ID.
module param_ddr_writer #(
  parameter int BEAT_WIDTH = 512,
  parameter int MAX_WIDTH  = 8192,
  parameter int MAX_BEATS  = MAX_WIDTH / BEAT_WIDTH,
  parameter int ADDR_W     = 28,
  parameter int BASE_ADDR  = 0,
  parameter int SLOT_BYTES = MAX_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  param_valid,
  output logic                  param_ready,
  input  logic [5:0]            param_id,
  input  logic [4:0]            param_len,
  input  logic [MAX_WIDTH-1:0]  param_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [BEAT_WIDTH-1:0] wr_data,
  output logic                  wr_last,
  output logic                  busy,
  output logic                  err,
  output logic [7:0]            done_cnt
);

  localparam int         BEAT_BYTES = BEAT_WIDTH / 8;
  localparam logic [5:0] MAX_LEN    = 6'(MAX_BEATS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_d;
  logic [MAX_WIDTH-1:0]   shift_reg;
  logic [5:0]             id_q;
  logic [4:0]             len_q;
  logic [4:0]             beat_cnt;
  logic                   len_ok;
  logic                   load;
  logic                   reject;
  logic                   beat_fire;

  assign len_ok      = (param_len != 5'd0) && ({1'b0, param_len} <= MAX_LEN);
  assign param_ready = (state == IDLE) && !rst;
  assign wr_valid    = (state == SEND);
  assign busy        = (state == SEND);
  assign wr_data     = shift_reg[BEAT_WIDTH-1:0];
  assign wr_last     = (state == SEND) && (beat_cnt == len_q - 5'd1);

  // Slot base plus beat offset; wraps at ADDR_W like the DDR address bus.
  assign wr_addr = ADDR_W'(BASE_ADDR)
                 + ADDR_W'(id_q) * ADDR_W'(SLOT_BYTES)
                 + ADDR_W'(beat_cnt) * ADDR_W'(BEAT_BYTES);

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    reject    = 1'b0;
    beat_fire = 1'b0;
    case (state)
      IDLE: begin
        if (param_valid && param_ready) begin
          if (len_ok) begin
            load    = 1'b1;
            state_d = SEND;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      SEND: begin
        if (wr_ready) begin
          beat_fire = 1'b1;
          if (wr_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      id_q      <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      done_cnt  <= '0;
    end else begin
      state <= state_d;
      err   <= reject;
      if (load) begin
        shift_reg <= param_data;
        id_q      <= param_id;
        len_q     <= param_len;
        beat_cnt  <= '0;
      end else if (beat_fire) begin
        // Least-significant beat leaves first, so the next one slides down.
        shift_reg <= shift_reg >> BEAT_WIDTH;
        beat_cnt  <= beat_cnt + 5'd1;
        if (wr_last) done_cnt <= done_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_param_ddr_writer.sv
// Directed bench for param_ddr_writer: single beat, full width, stalls,
// illegal lengths, reset mid-burst and done_cnt wrap.
module tb_param_ddr_writer;

  logic          clk;
  logic          rst;
  logic          param_valid;
  logic          param_ready;
  logic [5:0]    param_id;
  logic [4:0]    param_len;
  logic [8191:0] param_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [27:0]   wr_addr;
  logic [511:0]  wr_data;
  logic          wr_last;
  logic          busy;
  logic          err;
  logic [7:0]    done_cnt;

  int checks = 0;
  int errors = 0;

  param_ddr_writer dut (
    .clk        (clk),
    .rst        (rst),
    .param_valid(param_valid),
    .param_ready(param_ready),
    .param_id   (param_id),
    .param_len  (param_len),
    .param_data (param_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .busy       (busy),
    .err        (err),
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [511:0] observed,
                              input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_flag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Called at a negedge; presents one parameter for exactly one handshake edge.
  task automatic apply_stimulus(input logic [5:0] id, input logic [4:0] len,
                                input logic [8191:0] data);
    check_flag("ready_before_accept", param_ready, 1'b1);
    param_valid = 1'b1;
    param_id    = id;
    param_len   = len;
    param_data  = data;
    @(negedge clk);
    param_valid = 1'b0;
    param_data  = '0;
  endtask

  initial begin
    logic [8191:0] big;
    logic [6:0]    pattern;
    int            e;

    rst         = 1'b1;
    param_valid = 1'b0;
    param_id    = '0;
    param_len   = '0;
    param_data  = '0;
    wr_ready    = 1'b1;

    $display("[TB] reset state");
    @(negedge clk);
    check_flag  ("rst_param_ready", param_ready, 1'b0);
    check_flag  ("rst_wr_valid",    wr_valid,    1'b0);
    check_flag  ("rst_wr_last",     wr_last,     1'b0);
    check_flag  ("rst_busy",        busy,        1'b0);
    check_flag  ("rst_err",         err,         1'b0);
    check_output("rst_done_cnt",    512'(done_cnt), 512'd0);
    check_output("rst_wr_addr",     512'(wr_addr),  512'd0);
    check_output("rst_wr_data",     wr_data,        512'd0);
    rst = 1'b0;
    @(negedge clk);
    check_flag("idle_param_ready", param_ready, 1'b1);

    $display("[TB] single beat, upper bits junk");
    big = '1;
    big[511:0] = 512'hA5;
    apply_stimulus(6'd3, 5'd1, big);
    check_flag  ("t1_wr_valid", wr_valid, 1'b1);
    check_flag  ("t1_busy",     busy,     1'b1);
    check_flag  ("t1_ready_lo", param_ready, 1'b0);
    check_output("t1_addr",     512'(wr_addr), 512'h0C00);
    check_output("t1_data",     wr_data, 512'hA5);
    check_flag  ("t1_last",     wr_last, 1'b1);
    @(negedge clk);
    check_flag  ("t1_valid_off", wr_valid, 1'b0);
    check_flag  ("t1_busy_off",  busy,     1'b0);
    check_flag  ("t1_ready_hi",  param_ready, 1'b1);
    check_output("t1_done",      512'(done_cnt), 512'd1);

    $display("[TB] full 16-beat parameter");
    for (int k = 0; k < 16; k++) big[512*k +: 512] = 512'(k);
    apply_stimulus(6'd1, 5'd16, big);
    for (int k = 0; k < 16; k++) begin
      check_flag  ("t2_valid", wr_valid, 1'b1);
      check_output("t2_addr",  512'(wr_addr), 512'(32'h400 + 32'(k) * 32'h40));
      check_output("t2_data",  wr_data, 512'(k));
      check_flag  ("t2_last",  wr_last, k == 15);
      @(negedge clk);
    end
    check_flag  ("t2_valid_off", wr_valid, 1'b0);
    check_output("t2_done",      512'(done_cnt), 512'd2);

    $display("[TB] backpressure");
    big = '1;
    for (int k = 0; k < 4; k++) big[512*k +: 512] = 512'(32'hB000 + k);
    apply_stimulus(6'd0, 5'd4, big);
    pattern = 7'b1101001;
    e = 0;
    for (int i = 0; i < 7; i++) begin
      wr_ready = pattern[i];
      check_flag  ("t3_valid", wr_valid, 1'b1);
      check_output("t3_addr",  512'(wr_addr), 512'(32'(e) * 32'h40));
      check_output("t3_data",  wr_data, 512'(32'hB000 + e));
      check_flag  ("t3_last",  wr_last, e == 3);
      if (pattern[i]) e++;
      @(negedge clk);
    end
    wr_ready = 1'b1;
    check_output("t3_beats",     512'(e), 512'd4);
    check_flag  ("t3_valid_off", wr_valid, 1'b0);
    check_output("t3_done",      512'(done_cnt), 512'd3);

    $display("[TB] illegal lengths");
    apply_stimulus(6'd5, 5'd0, '1);
    check_flag  ("t4a_err",   err, 1'b1);
    check_flag  ("t4a_valid", wr_valid, 1'b0);
    check_flag  ("t4a_ready", param_ready, 1'b1);
    @(negedge clk);
    check_flag  ("t4a_err_off", err, 1'b0);
    check_output("t4a_done",    512'(done_cnt), 512'd3);
    apply_stimulus(6'd6, 5'd17, '1);
    check_flag  ("t4b_err",   err, 1'b1);
    check_flag  ("t4b_valid", wr_valid, 1'b0);
    check_flag  ("t4b_ready", param_ready, 1'b1);
    @(negedge clk);
    check_flag  ("t4b_err_off", err, 1'b0);
    check_flag  ("t4b_valid2",  wr_valid, 1'b0);
    check_output("t4b_done",    512'(done_cnt), 512'd3);

    $display("[TB] reset mid-burst");
    for (int k = 0; k < 16; k++) big[512*k +: 512] = 512'(32'hC000 + k);
    apply_stimulus(6'd2, 5'd16, big);
    for (int k = 0; k < 5; k++) begin
      check_output("t5_addr", 512'(wr_addr), 512'(32'h800 + 32'(k) * 32'h40));
      check_output("t5_data", wr_data, 512'(32'hC000 + k));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check_flag  ("t5_valid_off", wr_valid, 1'b0);
    check_flag  ("t5_busy_off",  busy, 1'b0);
    check_flag  ("t5_ready_rst", param_ready, 1'b0);
    check_output("t5_done_clr",  512'(done_cnt), 512'd0);
    rst = 1'b0;
    @(negedge clk);
    big = '0;
    big[511:0]    = 512'h11;
    big[1023:512] = 512'h22;
    apply_stimulus(6'd4, 5'd2, big);
    check_output("t5_new_addr0", 512'(wr_addr), 512'h1000);
    check_output("t5_new_data0", wr_data, 512'h11);
    check_flag  ("t5_new_last0", wr_last, 1'b0);
    @(negedge clk);
    check_output("t5_new_addr1", 512'(wr_addr), 512'h1040);
    check_output("t5_new_data1", wr_data, 512'h22);
    check_flag  ("t5_new_last1", wr_last, 1'b1);
    @(negedge clk);
    check_flag  ("t5_new_valid_off", wr_valid, 1'b0);
    check_output("t5_new_done",      512'(done_cnt), 512'd1);

    $display("[TB] done_cnt wrap");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("t6_start", 512'(done_cnt), 512'd0);
    for (int i = 0; i < 256; i++) begin
      big = '0;
      big[511:0] = 512'(i);
      apply_stimulus(6'(i), 5'd1, big);
      check_flag("t6_last", wr_last, 1'b1);
      @(negedge clk);
      if (i == 254) check_output("t6_pre_wrap", 512'(done_cnt), 512'd255);
    end
    check_output("t6_wrapped", 512'(done_cnt), 512'd0);
    check_flag  ("t6_err",     err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
